// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch stage and IF/ID pipeline register for the 16-bit processor.
// Owns the PC. Issues requests to instruction memory over a req/rdy handshake.
// Latches each fetched word together with its PC+2 into IF/ID.
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   IMEM_AW     instruction address width (byte address, always even)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   stall       hazard unit: hold PC and IF/ID
//   flush       taken branch: redirect PC to br_target, squash IF/ID
//   br_target   redirect address (bit 0 ignored)
//   imem_req    fetch request
//   imem_addr   fetch address (the PC)
//   imem_rdata  instruction word, valid when imem_req && imem_rdy
//   imem_rdy    memory accepts the request and returns data this cycle
//   if_id_instr latched instruction
//   if_id_pc2   latched PC+2
//   if_id_valid IF/ID holds a real instruction
//   halted      HLT (opcode 4'hF) fetched; fetch frozen until flush or reset
//
// Optional feature (macro FETCH_PERF_EN):
//   perf_fetch_cnt  saturating count of accepted fetches (flushed ones included)
//   perf_wait_cnt   saturating count of cycles spent in WAIT

module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          IMEM_AW  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic [15:0]        br_target,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               imem_rdy,
    output logic [15:0]        if_id_instr,
    output logic [15:0]        if_id_pc2,
    output logic               if_id_valid,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [15:0] target_even;
    logic        started;
    logic        accept;
    logic        is_hlt;
    logic        hold_valid;
    logic [15:0] hold_instr;
    logic [15:0] hold_pc2;
    logic        br_target_unused;

    assign pc_plus2         = pc + 16'd2;
    assign target_even      = {br_target[15:1], 1'b0};
    assign br_target_unused = br_target[0];
    assign is_hlt           = (imem_rdata[15:12] == 4'hF);
    assign imem_addr        = IMEM_AW'(pc);
    assign halted           = (state == HALT);

    // A data beat arriving in a flush cycle belongs to the squashed path.
    assign accept = imem_req && imem_rdy && !flush;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request logic.
    // 'started' keeps the request low during reset and the first cycle after it.
    // A full hold buffer must drain into IF/ID before another fetch may start.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;

        case (state)
            FETCH: begin
                imem_req = started && !stall && !hold_valid;
                if (imem_req && imem_rdy) begin
                    state_next = is_hlt ? HALT : FETCH;
                end else if (imem_req) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    state_next = is_hlt ? HALT : FETCH;
                end
            end
            HALT: begin
                imem_req = 1'b0;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        if (flush) begin
            state_next = FETCH;
        end
    end

    // PC, IF/ID register and the one-entry hold buffer.
    // A word accepted while stalled is parked in the hold buffer. It moves to
    // IF/ID on the first non-stalled edge, before any new fetch is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            pc          <= RESET_PC;
            if_id_instr <= 16'h0000;
            if_id_pc2   <= 16'h0000;
            if_id_valid <= 1'b0;
            hold_valid  <= 1'b0;
            hold_instr  <= 16'h0000;
            hold_pc2    <= 16'h0000;
        end else begin
            started <= 1'b1;
            if (flush) begin
                pc          <= target_even;
                if_id_valid <= 1'b0;
                hold_valid  <= 1'b0;
            end else begin
                // HLT leaves the PC pointing at itself.
                if (accept && !is_hlt) begin
                    pc <= pc_plus2;
                end

                if (stall) begin
                    if (accept) begin
                        hold_valid <= 1'b1;
                        hold_instr <= imem_rdata;
                        hold_pc2   <= pc_plus2;
                    end
                end else if (hold_valid) begin
                    if_id_instr <= hold_instr;
                    if_id_pc2   <= hold_pc2;
                    if_id_valid <= 1'b1;
                    hold_valid  <= 1'b0;
                end else if (accept) begin
                    if_id_instr <= imem_rdata;
                    if_id_pc2   <= pc_plus2;
                    if_id_valid <= 1'b1;
                end else begin
                    if_id_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating performance counters. Handshakes in a flush cycle still count
    // as fetches, since the memory did complete them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 16'h0000;
            perf_wait_cnt  <= 16'h0000;
        end else begin
            if (imem_req && imem_rdy && (perf_fetch_cnt != 16'hFFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            end
            if ((state == WAIT) && (perf_wait_cnt != 16'hFFFF)) begin
                perf_wait_cnt <= perf_wait_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed testbench for fetch_stage. The stimulus drives the memory response
// cycle by cycle and pushes the expected IF/ID pair for every accepted fetch.
// A monitor pops and compares whenever IF/ID presents a valid instruction that
// the ID stage consumes (no stall that cycle).

module tb_fetch_stage;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [15:0] br_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_rdy;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc2;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_wait_cnt;
`endif

    exp_t expq[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .IMEM_AW  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rdy    (imem_rdy),
        .if_id_instr (if_id_instr),
        .if_id_pc2   (if_id_pc2),
        .if_id_valid (if_id_valid),
        .halted      (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge, then return at the
    // falling edge so the caller can sample outputs for that cycle.
    task automatic applyStimulus(input logic rdy, input logic st, input logic fl,
                                 input logic [15:0] tgt, input logic [15:0] data);
        @(posedge clk);
        #1;
        imem_rdy   = rdy;
        stall      = st;
        flush      = fl;
        br_target  = tgt;
        imem_rdata = data;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [15:0] instr, input logic [15:0] pc2);
        exp_t e;
        e.instr = instr;
        e.pc2   = pc2;
        expq.push_back(e);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && if_id_valid && !stall) begin
            assert_count++;
            if (expq.size() == 0) begin
                fail_count++;
                $display("[TB] FAIL ifid_unexpected: got instr=%h pc2=%h, expected no instruction",
                         if_id_instr, if_id_pc2);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (if_id_instr !== e.instr || if_id_pc2 !== e.pc2) begin
                    fail_count++;
                    $display("[TB] FAIL ifid_pair: got instr=%h pc2=%h, expected instr=%h pc2=%h",
                             if_id_instr, if_id_pc2, e.instr, e.pc2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;

        rst_n      = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        br_target  = 16'h0000;
        imem_rdata = 16'h0000;
        imem_rdy   = 1'b0;

        // Reset values.
        @(posedge clk);
        #1;
        checkOutput("rst_imem_req",    {15'd0, imem_req},    16'h0000);
        checkOutput("rst_halted",      {15'd0, halted},      16'h0000);
        checkOutput("rst_valid",       {15'd0, if_id_valid}, 16'h0000);
        checkOutput("rst_instr",       if_id_instr,          16'h0000);
        checkOutput("rst_pc2",         if_id_pc2,            16'h0000);
        checkOutput("rst_imem_addr",   imem_addr,            16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back zero-wait fetches of 0123 and 1456.
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0123);
            if (imem_req) seen = 1'b1;
        end
        checkOutput("first_req_seen", {15'd0, seen},      16'h0001);
        checkOutput("first_req_addr", imem_addr,          16'h0000);
        pushExpected(16'h0123, 16'h0002);

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1456);
        checkOutput("t1_valid_rise",  {15'd0, if_id_valid}, 16'h0001);
        checkOutput("t1_addr2",       imem_addr,            16'h0002);
        pushExpected(16'h1456, 16'h0004);

        // Three wait cycles at 0x0004, accept on the fourth request cycle.
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("w_addr_c0", imem_addr,          16'h0004);
        checkOutput("w_req_c0",  {15'd0, imem_req},  16'h0001);
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            checkOutput("w_addr_hold",  imem_addr,            16'h0004);
            checkOutput("w_req_hold",   {15'd0, imem_req},    16'h0001);
            checkOutput("w_valid_low",  {15'd0, if_id_valid}, 16'h0000);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h2111);
        checkOutput("w_addr_c3",  imem_addr,            16'h0004);
        checkOutput("w_req_c3",   {15'd0, imem_req},    16'h0001);
        checkOutput("w_valid_c3", {15'd0, if_id_valid}, 16'h0000);
        pushExpected(16'h2111, 16'h0006);

        // Fetch at 0x0006 misses, entering WAIT.
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("w_addr_next", imem_addr, 16'h0006);
`ifdef FETCH_PERF_EN
        checkOutput("perf_wait_cnt", perf_wait_cnt, 16'd3);
`endif

        // Stall coincides with the accept of 2AAA while in WAIT.
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 16'h2AAA);
        checkOutput("s_req_wait",  {15'd0, imem_req},    16'h0001);
        pushExpected(16'h2AAA, 16'h0008);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 16'h7777);
        checkOutput("s_req_low",   {15'd0, imem_req},    16'h0000);
        checkOutput("s_instr_hold", if_id_instr,         16'h2111);
        checkOutput("s_valid_hold", {15'd0, if_id_valid}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h7777);
        checkOutput("s_req_drain", {15'd0, imem_req},    16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("s_instr_out", if_id_instr,          16'h2AAA);
        checkOutput("s_valid_out", {15'd0, if_id_valid}, 16'h0001);
        checkOutput("s_addr_next", imem_addr,            16'h0008);

        // Flush to odd target while in WAIT, with rdy in the same cycle.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0041, 16'h3333);
        checkOutput("f_in_wait", {15'd0, imem_req}, 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000);
        checkOutput("f_valid",  {15'd0, if_id_valid}, 16'h0000);
        checkOutput("f_addr",   imem_addr,            16'h0040);
        checkOutput("f_req",    {15'd0, imem_req},    16'h0001);

        // HLT fetched at 0x0010.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'hF000);
        checkOutput("h_addr", imem_addr, 16'h0010);
        pushExpected(16'hF000, 16'h0012);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234);
        checkOutput("h_halted",   {15'd0, halted},      16'h0001);
        checkOutput("h_req_low",  {15'd0, imem_req},    16'h0000);
        checkOutput("h_pc_same",  imem_addr,            16'h0010);
        checkOutput("h_valid",    {15'd0, if_id_valid}, 16'h0001);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234);
        checkOutput("h_halted2",  {15'd0, halted},      16'h0001);
        checkOutput("h_req_low2", {15'd0, imem_req},    16'h0000);
        checkOutput("h_bubble",   {15'd0, if_id_valid}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h5555);
        checkOutput("h_unhalt",   {15'd0, halted},      16'h0000);
        checkOutput("h_new_addr", imem_addr,            16'h0020);
        checkOutput("h_new_req",  {15'd0, imem_req},    16'h0001);
        pushExpected(16'h5555, 16'h0022);

        // PC wrap at 0xFFFE.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("wr_addr", imem_addr, 16'hFFFE);
        pushExpected(16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("wr_next_addr", imem_addr,            16'h0000);
        checkOutput("wr_pc2",       if_id_pc2,            16'h0000);
        checkOutput("wr_valid",     {15'd0, if_id_valid}, 16'h0001);

        // Asynchronous reset in the middle of a WAIT cycle.
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("ar_req_before", {15'd0, imem_req}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_req_drop", {15'd0, imem_req},    16'h0000);
        checkOutput("ar_addr",     imem_addr,            16'h0000);
        checkOutput("ar_valid",    {15'd0, if_id_valid}, 16'h0000);
        checkOutput("ar_instr",    if_id_instr,          16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end

        checkOutput("sb_empty", 16'(expq.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
